contador_bcd_param: RTL and testbench

//  Parametrised, cascadable modulo-N multi-digit up/down counter.
//  - Generalises the single-digit 0..9 counter to DIGITS digits of configurable modulus.
//  - Adds up/down counting, count enable, parallel load and a terminal-count output.
//  - Adds a registered wrap pulse.
//  - Feeds display decoders and timebase dividers; cascades via TC -> EN of the next instance.

---
 rtl/contador_bcd_param.sv | 93 +++++++++
 tb/tb_contador_bcd_param.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/contador_bcd_param.sv
// Cascadable modulo-MODULUS, DIGITS-digit up/down counter with load, terminal count and wrap pulse.
// Define COUNTER_SATURATE_EN to hold at the terminal value instead of wrapping.
module contador_bcd_param #(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned MODULUS = 10
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  EN,
  input  logic                  UP,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  TC,
  output logic                  CARRY_OUT
);

  localparam logic [3:0] MaxDigit = 4'(MODULUS - 1);

  logic [4*DIGITS-1:0] q_q;
  logic [4*DIGITS-1:0] q_step;
  logic [4*DIGITS-1:0] q_load;
  logic                carry_q;
  logic                wrap;
  logic                all_max;
  logic                all_zero;

  // Ripple the carry/borrow through the digits; a surviving chain means the whole count wrapped.
  always_comb begin
    logic       chain;
    logic [3:0] dig;
    logic [3:0] lv;
    q_step   = q_q;
    q_load   = '0;
    chain    = 1'b1;
    all_max  = 1'b1;
    all_zero = 1'b1;
    dig      = '0;
    lv       = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig      = q_q[4*i +: 4];
      all_max  = all_max & (dig == MaxDigit);
      all_zero = all_zero & (dig == 4'd0);
      if (chain) begin
        if (UP) begin
          if (dig == MaxDigit) begin
            q_step[4*i +: 4] = 4'd0;
          end else begin
            q_step[4*i +: 4] = dig + 4'd1;
            chain            = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            q_step[4*i +: 4] = MaxDigit;
          end else begin
            q_step[4*i +: 4] = dig - 4'd1;
            chain            = 1'b0;
          end
        end
      end
      lv               = LOAD_VAL[4*i +: 4];
      q_load[4*i +: 4] = (lv > MaxDigit) ? MaxDigit : lv;
    end
    wrap = chain;
  end

  assign TC        = EN & ~LOAD & (UP ? all_max : all_zero);
  assign Q         = q_q;
  assign CARRY_OUT = carry_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_q     <= '0;
      carry_q <= 1'b0;
    end else if (LOAD) begin
      q_q     <= q_load;
      carry_q <= 1'b0;
    end else if (EN) begin
`ifdef COUNTER_SATURATE_EN
      if (!TC) begin
        q_q <= q_step;
      end
      carry_q <= 1'b0;
`else
      q_q     <= q_step;
      carry_q <= wrap;
`endif
    end else begin
      carry_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_contador_bcd_param.sv
// Scoreboard bench: two instances (2 x mod-10 and 1 x mod-6) checked against an integer-valued model.
module tb_contador_bcd_param;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       UP = 1'b1;
  logic       EN_a = 1'b0, LOAD_a = 1'b0;
  logic [7:0] LV_a = '0;
  logic [7:0] Q_a;
  logic       TC_a, CO_a;
  logic       EN_b = 1'b0, LOAD_b = 1'b0;
  logic [3:0] LV_b = '0;
  logic [3:0] Q_b;
  logic       TC_b, CO_b;

  always #5 CLK = ~CLK;

  contador_bcd_param #(.DIGITS(2), .MODULUS(10)) u_dut_a (
    .CLK(CLK), .RESET(RESET), .EN(EN_a), .UP(UP), .LOAD(LOAD_a), .LOAD_VAL(LV_a),
    .Q(Q_a), .TC(TC_a), .CARRY_OUT(CO_a)
  );

  contador_bcd_param #(.DIGITS(1), .MODULUS(6)) u_dut_b (
    .CLK(CLK), .RESET(RESET), .EN(EN_b), .UP(UP), .LOAD(LOAD_b), .LOAD_VAL(LV_b),
    .Q(Q_b), .TC(TC_b), .CARRY_OUT(CO_b)
  );

  typedef struct {
    bit         chk;
    logic [7:0] q;
    bit         c;
    bit         tc;
    logic [3:0] qb;
    bit         cb;
    bit         tcb;
  } exp_t;

  exp_t   sb[$];
  int     total = 0;
  int     bad = 0;
  longint val_a = 0, val_b = 0;
  bit     c_a = 0, c_b = 0;
  bit     mvalid = 0;

  function automatic longint pw(int m, int d);
    longint r = 1;
    for (int i = 0; i < d; i++) r = r * m;
    return r;
  endfunction

  function automatic logic [31:0] to_q(longint val, int m, int d);
    logic [31:0] r = '0;
    longint      v = val;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % m);
      v = v / m;
    end
    return r;
  endfunction

  function automatic longint from_load(logic [31:0] lv, int m, int d);
    longint r = 0;
    int     dig;
    for (int i = 0; i < d; i++) begin
      dig = int'(lv[4*i +: 4]);
      if (dig > m - 1) dig = m - 1;
      r = r + longint'(dig) * pw(m, i);
    end
    return r;
  endfunction

  function automatic bit tc_model(int m, int d, bit ld, bit en, bit up, longint val);
    return en && !ld && (up ? (val == pw(m, d) - 1) : (val == 0));
  endfunction

  task automatic step_model(input int m, input int d, input bit rst, input bit ld, input bit en,
                            input bit up, input logic [31:0] lv, inout longint val, inout bit c);
    longint top = pw(m, d) - 1;
    bit     at_term;
    if (rst) begin
      val = 0;
      c   = 0;
    end else if (ld) begin
      val = from_load(lv, m, d);
      c   = 0;
    end else if (en) begin
      at_term = up ? (val == top) : (val == 0);
`ifdef COUNTER_SATURATE_EN
      if (!at_term) val = up ? val + 1 : val - 1;
      c = 0;
`else
      if (up) val = at_term ? 0 : val + 1;
      else    val = at_term ? top : val - 1;
      c = at_term;
`endif
    end else begin
      c = 0;
    end
  endtask

  // Drive one cycle; record what the DUTs must show now, then advance the model across the next edge.
  task automatic cyc(input bit rst, input bit en, input bit up, input bit ld, input logic [7:0] lv,
                     input bit enb, input bit ldb, input logic [3:0] lvb);
    exp_t        e;
    logic [31:0] t;
    @(posedge CLK);
    #1;
    RESET = rst; EN_a = en; UP = up; LOAD_a = ld; LV_a = lv;
    EN_b = enb; LOAD_b = ldb; LV_b = lvb;
    e.chk = mvalid;
    t     = to_q(val_a, 10, 2);
    e.q   = t[7:0];
    e.c   = c_a;
    e.tc  = tc_model(10, 2, ld, en, up, val_a);
    t     = to_q(val_b, 6, 1);
    e.qb  = t[3:0];
    e.cb  = c_b;
    e.tcb = tc_model(6, 1, ldb, enb, up, val_b);
    sb.push_back(e);
    step_model(10, 2, rst, ld, en, up, {24'h0, lv}, val_a, c_a);
    step_model(6, 1, rst, ldb, enb, up, {28'h0, lvb}, val_b, c_b);
    if (rst) mvalid = 1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compare whatever the DUTs present against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          check("q_a",     {24'h0, Q_a},  {24'h0, e.q});
          check("carry_a", {31'h0, CO_a}, {31'h0, e.c});
          check("tc_a",    {31'h0, TC_a}, {31'h0, e.tc});
          check("q_b",     {28'h0, Q_b},  {28'h0, e.qb});
          check("carry_b", {31'h0, CO_b}, {31'h0, e.cb});
          check("tc_b",    {31'h0, TC_b}, {31'h0, e.tcb});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired, pending=%0d", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    // Reset dominates LOAD and EN.
    repeat (2) cyc(1, 1, 1, 1, 8'h37, 1, 1, 4'h3);
    // Full up-count with wrap.
    repeat (100) cyc(0, 1, 1, 0, 8'h00, 1, 0, 4'h0);
    // Load 05 then count down through the wrap.
    cyc(0, 0, 1, 1, 8'h05, 1, 0, 4'h0);
    repeat (7) cyc(0, 1, 0, 0, 8'h00, 1, 0, 4'h0);
    // Clamped load with EN high.
    cyc(0, 1, 1, 1, 8'hFC, 1, 1, 4'hF);
    // Direction toggling, hold, mid-count reset.
    cyc(0, 0, 1, 1, 8'h42, 1, 0, 4'h0);
    cyc(0, 1, 1, 0, 8'h00, 1, 0, 4'h0);
    cyc(0, 1, 0, 0, 8'h00, 1, 0, 4'h0);
    cyc(0, 1, 1, 0, 8'h00, 1, 0, 4'h0);
    repeat (2) cyc(0, 0, 1, 0, 8'h00, 0, 0, 4'h0);
    cyc(1, 1, 1, 0, 8'h00, 1, 0, 4'h0);
    // Approach the top from 98, then reverse.
    cyc(0, 0, 1, 1, 8'h98, 1, 0, 4'h0);
    repeat (3) cyc(0, 1, 1, 0, 8'h00, 1, 0, 4'h0);
    cyc(0, 1, 0, 0, 8'h00, 1, 0, 4'h0);
    cyc(0, 0, 1, 0, 8'h00, 1, 0, 4'h0);
    // Randomised traffic.
    repeat (400) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
          ($urandom_range(0, 9) == 0), 8'($urandom_range(0, 255)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)));
    end
    cyc(0, 0, 1, 0, 8'h00, 0, 0, 4'h0);
    repeat (3) @(negedge CLK);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
